// File: rtl/jk_pkg.sv
// Shared constants and JK pair encoding used by the JK counter and its bit cells.
package jk_pkg;

    localparam logic MODE_COUNT = 1'b0;
    localparam logic MODE_JK    = 1'b1;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    typedef enum logic [1:0] {
        JK_HOLD = 2'b00,
        JK_RST  = 2'b01,
        JK_SET  = 2'b10,
        JK_TOG  = 2'b11
    } jk_op_e;

    // Returns the {j, k} input pair that makes a JK cell perform the given operation.
    function automatic logic [1:0] jk_encode(input jk_op_e op);
        logic [1:0] pair;
        case (op)
            JK_RST:  pair = 2'b01;
            JK_SET:  pair = 2'b10;
            JK_TOG:  pair = 2'b11;
            default: pair = 2'b00;
        endcase
        return pair;
    endfunction

endpackage

// File: rtl/jk_ff_cell.sv
// Single JK flip-flop with synchronous reset to a per-bit value and a clock enable.
module jk_ff_cell
    import jk_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic rst_val,
    input  logic ce,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qn
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= rst_val;
        end else if (ce) begin
            case ({j, k})
                jk_encode(JK_RST): q <= 1'b0;
                jk_encode(JK_SET): q <= 1'b1;
                jk_encode(JK_TOG): q <= ~q;
                default:           q <= q;
            endcase
        end
    end

    assign qn = ~q;

endmodule

// File: rtl/jk_counter.sv
// Modulo-N up/down counter or raw JK register bank built from WIDTH JK cells;
// the top steers each cell's J/K pair for counting, wrap correction and load.
module jk_counter
    import jk_pkg::*;
#(
    parameter int              WIDTH     = 4,
    parameter longint unsigned MODULUS   = 16,
    parameter longint unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             tc,
    output logic             wrapped,
    output logic             load_err
);

    localparam logic [WIDTH-1:0] MAX_VAL    = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_Q      = WIDTH'(RESET_VAL);
    localparam bit               FULL_RANGE = (MODULUS == (64'd1 << WIDTH));

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("jk_counter: WIDTH must be in 1..32");
    end
    if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
        $error("jk_counter: MODULUS must be in 2..2**WIDTH");
    end
    if (RESET_VAL >= MODULUS) begin : g_bad_reset
        $error("jk_counter: RESET_VAL must be below MODULUS");
    end

    logic q_out_rng;
    logic load_bad;

    // With a full binary range every WIDTH-bit value is legal.
    if (FULL_RANGE) begin : g_full
        assign q_out_rng = 1'b0;
        assign load_bad  = 1'b0;
    end else begin : g_partial
        assign q_out_rng = (q > MAX_VAL);
        assign load_bad  = (load_val > MAX_VAL);
    end

    logic wrap_up;
    logic wrap_dn;
    logic count_wrap;

    assign wrap_up    = (q == MAX_VAL) | q_out_rng;
    assign wrap_dn    = (q == '0) | q_out_rng;
    assign count_wrap = (up_dn == DIR_UP) ? wrap_up : wrap_dn;

    logic [WIDTH-1:0] j_drv;
    logic [WIDTH-1:0] k_drv;
    logic [WIDTH-1:0] toggle;

    // Ripple carry/borrow: a bit toggles when all lower bits are 1 (up) or 0 (down).
    always_comb begin
        logic carry;
        carry  = 1'b1;
        toggle = '0;
        for (int i = 0; i < WIDTH; i++) begin
            toggle[i] = carry;
            carry     = carry & ((up_dn == DIR_UP) ? q[i] : ~q[i]);
        end
    end

    always_comb begin
        j_drv = '0;
        k_drv = '0;
        if (load) begin
            if (!load_bad) begin
                for (int i = 0; i < WIDTH; i++) begin
                    {j_drv[i], k_drv[i]} = jk_encode(load_val[i] ? JK_SET : JK_RST);
                end
            end
        end else if (en) begin
            if (mode == MODE_JK) begin
                j_drv = j;
                k_drv = k;
            end else if (count_wrap) begin
                // Wrap and out-of-range recovery force the target value bit by bit.
                for (int i = 0; i < WIDTH; i++) begin
                    if (up_dn == DIR_UP) begin
                        {j_drv[i], k_drv[i]} = jk_encode(JK_RST);
                    end else begin
                        {j_drv[i], k_drv[i]} = jk_encode(MAX_VAL[i] ? JK_SET : JK_RST);
                    end
                end
            end else begin
                j_drv = toggle;
                k_drv = toggle;
            end
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_ff_cell u_cell (
            .clk     (clk),
            .rst     (rst),
            .rst_val (RST_Q[i]),
            .ce      (load | en),
            .j       (j_drv[i]),
            .k       (k_drv[i]),
            .q       (q[i]),
            .qn      (qn[i])
        );
    end

    assign tc = en & (mode == MODE_COUNT) &
                (((up_dn == DIR_UP) & (q == MAX_VAL)) | ((up_dn == DIR_DN) & (q == '0)));

    always_ff @(posedge clk) begin
        if (rst) begin
            wrapped  <= 1'b0;
            load_err <= 1'b0;
        end else begin
            wrapped  <= ~load & en & (mode == MODE_COUNT) & count_wrap;
            load_err <= load & load_bad;
        end
    end

endmodule

// File: tb/tb_jk_counter.sv
// Self-checking bench for jk_counter (WIDTH=4, MODULUS=10) against an arithmetic reference model.
module tb_jk_counter;

    localparam int W   = 4;
    localparam int MOD = 10;

    logic         clk = 1'b0;
    logic         rst, en, mode, up_dn, load;
    logic [W-1:0] load_val, j, k;
    logic [W-1:0] q, qn;
    logic         tc, wrapped, load_err;

    int n_cmp = 0;
    int n_err = 0;

    int m_q  = 0;
    int m_wr = 0;
    int m_le = 0;

    jk_counter #(.WIDTH(W), .MODULUS(MOD), .RESET_VAL(0)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .up_dn(up_dn), .load(load),
        .load_val(load_val), .j(j), .k(k), .q(q), .qn(qn), .tc(tc),
        .wrapped(wrapped), .load_err(load_err)
    );

    always #5 clk = ~clk;

    // Reference: next state from the operational rules using plain integer arithmetic.
    task automatic step();
        int nq, nwr, nle;
        nq = m_q; nwr = 0; nle = 0;
        if (rst) begin
            nq = 0;
        end else if (load) begin
            if (int'(load_val) < MOD) nq = int'(load_val);
            else nle = 1;
        end else if (en) begin
            if (!mode) begin
                if (up_dn) begin
                    if (m_q >= MOD - 1) begin nq = 0; nwr = 1; end
                    else nq = m_q + 1;
                end else begin
                    if (m_q == 0 || m_q >= MOD) begin nq = MOD - 1; nwr = 1; end
                    else nq = m_q - 1;
                end
            end else begin
                nq = 0;
                for (int b = 0; b < W; b++) begin
                    int cur, nb;
                    cur = (m_q >> b) & 1;
                    if (!j[b] && !k[b]) nb = cur;
                    else if (!j[b] && k[b]) nb = 0;
                    else if (j[b] && !k[b]) nb = 1;
                    else nb = 1 - cur;
                    nq = nq + (nb << b);
                end
            end
        end
        @(posedge clk);
        #1;
        m_q = nq; m_wr = nwr; m_le = nle;
    endtask

    function automatic logic [2*W+1:0] dut_vec();
        return {q, qn, wrapped, load_err};
    endfunction

    function automatic logic [2*W+1:0] model_vec();
        logic [W-1:0] mq;
        mq = W'(m_q);
        return {mq, ~mq, m_wr[0], m_le[0]};
    endfunction

    function automatic logic model_tc();
        return en && !mode && ((up_dn && m_q == MOD - 1) || (!up_dn && m_q == 0));
    endfunction

    task automatic set_idle();
        rst = 0; en = 0; mode = 0; up_dn = 1; load = 0; load_val = '0; j = '0; k = '0;
    endtask

    task automatic test_reset();
        set_idle();
        rst = 1; en = 1; load = 1; load_val = 4'd7;
        repeat (2) step();
        n_cmp++;
        if (dut_vec() !== {4'h0, 4'hF, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset: got q/qn/wr/le=%b required %b", dut_vec(), {4'h0, 4'hF, 2'b00});
        end
        rst = 0; load = 0; en = 0;
    endtask

    task automatic test_up_wrap();
        int exp_q [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
        mode = 0; up_dn = 1; en = 1;
        for (int c = 0; c < 12; c++) begin
            #1;
            n_cmp++;
            if (tc !== (q == 4'd9)) begin
                n_err++;
                $display("FAIL up_tc[%0d]: got tc=%b q=%0d required tc=%b", c, tc, q, (q == 4'd9));
            end
            step();
            n_cmp++;
            if (q !== W'(exp_q[c]) || wrapped !== (exp_q[c] == 0) || dut_vec() !== model_vec()) begin
                n_err++;
                $display("FAIL up_count[%0d]: got q=%0d wr=%b required q=%0d wr=%b", c, q, wrapped,
                         exp_q[c], (exp_q[c] == 0));
            end
        end
    endtask

    task automatic test_down_load();
        int exp_q [5] = '{2, 1, 0, 9, 8};
        load = 1; load_val = 4'd3; en = 1;
        step();
        n_cmp++;
        if (q !== 4'd3 || wrapped !== 1'b0 || load_err !== 1'b0) begin
            n_err++;
            $display("FAIL load3: got q=%0d wr=%b le=%b required q=3 wr=0 le=0", q, wrapped, load_err);
        end
        load = 0; up_dn = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            n_cmp++;
            if (q !== W'(exp_q[c]) || wrapped !== (exp_q[c] == 9) || dut_vec() !== model_vec()) begin
                n_err++;
                $display("FAIL down_count[%0d]: got q=%0d wr=%b required q=%0d wr=%b", c, q, wrapped,
                         exp_q[c], (exp_q[c] == 9));
            end
        end
        load = 1; load_val = 4'd12;
        step();
        n_cmp++;
        if (q !== 4'd8 || load_err !== 1'b1 || wrapped !== 1'b0) begin
            n_err++;
            $display("FAIL bad_load: got q=%0d le=%b wr=%b required q=8 le=1 wr=0", q, load_err, wrapped);
        end
        load = 0; en = 0;
        step();
        n_cmp++;
        if (q !== 4'd8 || load_err !== 1'b0) begin
            n_err++;
            $display("FAIL bad_load_pulse: got q=%0d le=%b required q=8 le=0", q, load_err);
        end
    endtask

    task automatic test_enable_hold();
        en = 0; up_dn = 1;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++;
            if (tc !== 1'b0) begin
                n_err++;
                $display("FAIL hold_tc[%0d]: got %b required 0", c, tc);
            end
            step();
            n_cmp++;
            if (q !== 4'd8 || wrapped !== 1'b0) begin
                n_err++;
                $display("FAIL hold[%0d]: got q=%0d wr=%b required q=8 wr=0", c, q, wrapped);
            end
        end
        load = 1; load_val = 4'd5;
        step();
        n_cmp++;
        if (q !== 4'd5) begin
            n_err++;
            $display("FAIL hold_load: got q=%0d required 5", q);
        end
        load = 0;
    endtask

    task automatic test_jk_mode();
        logic [W-1:0] js [3] = '{4'b1100, 4'hF, 4'hF};
        logic [W-1:0] ks [3] = '{4'b1010, 4'hF, 4'h0};
        logic [W-1:0] eq [3] = '{4'b1101, 4'b0010, 4'b1111};
        mode = 1; en = 1; up_dn = 1;
        for (int c = 0; c < 3; c++) begin
            j = js[c]; k = ks[c];
            #1;
            n_cmp++;
            if (tc !== 1'b0) begin
                n_err++;
                $display("FAIL jk_tc[%0d]: got %b required 0", c, tc);
            end
            step();
            n_cmp++;
            if (q !== eq[c] || qn !== ~eq[c] || wrapped !== 1'b0) begin
                n_err++;
                $display("FAIL jk[%0d]: got q=%b wr=%b required q=%b wr=0", c, q, wrapped, eq[c]);
            end
        end
    endtask

    task automatic test_oor_return();
        mode = 0; up_dn = 1; en = 1; j = '0; k = '0;
        step();
        n_cmp++;
        if (q !== 4'd0 || wrapped !== 1'b1) begin
            n_err++;
            $display("FAIL oor_up: got q=%0d wr=%b required q=0 wr=1", q, wrapped);
        end
        repeat (4) step();
        n_cmp++;
        if (q !== 4'd4 || wrapped !== 1'b0) begin
            n_err++;
            $display("FAIL oor_count: got q=%0d wr=%b required q=4 wr=0", q, wrapped);
        end
        rst = 1; load = 1; load_val = 4'd7;
        step();
        n_cmp++;
        if (q !== 4'd0 || qn !== 4'hF || wrapped !== 1'b0 || load_err !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset: got q=%0d wr=%b le=%b required q=0 wr=0 le=0", q, wrapped, load_err);
        end
        rst = 0; load = 0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst      = ($urandom_range(0, 49) == 0);
            load     = ($urandom_range(0, 5) == 0);
            en       = ($urandom_range(0, 3) != 0);
            mode     = ($urandom_range(0, 3) == 0);
            up_dn    = $urandom_range(0, 1);
            load_val = W'($urandom_range(0, 15));
            j        = W'($urandom_range(0, 15));
            k        = W'($urandom_range(0, 15));
            #1;
            n_cmp++;
            if (tc !== model_tc()) begin
                n_err++;
                $display("FAIL rand_tc[%0d]: got %b required %b", c, tc, model_tc());
            end
            step();
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_err++;
                $display("FAIL rand_state[%0d]: got q/qn/wr/le=%b required %b", c, dut_vec(), model_vec());
            end
        end
    endtask

    initial begin
        set_idle();
        test_reset();
        test_up_wrap();
        test_down_load();
        test_enable_hold();
        test_jk_mode();
        test_oor_return();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
